// File: rtl/vj_scan_ctrl_pkg.sv
// Shared definitions for the vj frame scan sequencer: window geometry, scan
// states and the column-slot packing helper also used by vj's column input.
package vj_scan_ctrl_pkg;

    localparam int W_SIZE = 24;
    localparam int W1P    = 8;
    localparam int COL_W  = W1P * W_SIZE;
    localparam int SLOT_W = $clog2(W_SIZE);

    typedef logic [COL_W-1:0]  col_t;
    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [W1P-1:0]    pix_t;

    localparam slot_t LAST_SLOT = slot_t'(W_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_BAND_INIT,
        S_PAUSE,
        S_GATHER,
        S_ISSUE,
        S_WAIT_RDY,
        S_END_WAIT,
        S_GAP
    } scan_state_e;

    // Window row p lives at bits [W1P*(W_SIZE-p)-1 -: W1P], so row 0 is the MSB slot.
    function automatic col_t col_put(col_t col, slot_t p, pix_t px);
        col_t r;
        r = col;
        for (int i = 0; i < W_SIZE; i++) begin
            if (p == slot_t'(i)) begin
                r[W1P*(W_SIZE-i)-1 -: W1P] = px;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vj_col_gather.sv
// Reads one W_SIZE-tall pixel column from the frame RAM by walking the row
// stride, capturing each byte one cycle after its read into its column slot.
module vj_col_gather
    import vj_scan_ctrl_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          go_i,
    input  logic [AW-1:0] col_base_i,
    input  logic [AW-1:0] stride_i,
    input  pix_t          rd_data_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          col_valid_o,
    output col_t          col_data_o
);

    logic [AW-1:0] addr_q;
    logic          reading_q;
    slot_t         rdSlot_q;
    logic          capEn_q;
    slot_t         capSlot_q;
    logic          colValid_q;
    col_t          colData_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            reading_q  <= 1'b0;
            rdSlot_q   <= '0;
            capEn_q    <= 1'b0;
            capSlot_q  <= '0;
            colValid_q <= 1'b0;
            colData_q  <= '0;
        end else begin
            capEn_q   <= reading_q;
            capSlot_q <= rdSlot_q;
            if (go_i) begin
                reading_q  <= 1'b1;
                addr_q     <= col_base_i;
                rdSlot_q   <= '0;
                colValid_q <= 1'b0;
            end else if (reading_q) begin
                addr_q   <= addr_q + stride_i;
                rdSlot_q <= rdSlot_q + slot_t'(1);
                if (rdSlot_q == LAST_SLOT) begin
                    reading_q <= 1'b0;
                end
            end
            // The read issued last cycle returns now; the last slot completes the column.
            if (capEn_q) begin
                colData_q <= col_put(colData_q, capSlot_q, rd_data_i);
                if (capSlot_q == LAST_SLOT) begin
                    colValid_q <= 1'b1;
                end
            end
        end
    end

    assign rd_en_o     = reading_q;
    assign rd_addr_o   = addr_q;
    assign col_valid_o = colValid_q;
    assign col_data_o  = colData_q;

endmodule

// File: rtl/vj_scan_ctrl.sv
// Frame scan sequencer: walks a stored frame band by band, feeding vj with
// init pulses and W_SIZE-tall columns paced on its ready_for_next_col.
module vj_scan_ctrl
    import vj_scan_ctrl_pkg::*;
#(
    parameter int AW        = 20,
    parameter int RDY_GUARD = 2,
    parameter int BAND_GAP  = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [15:0]   pic_width,
    input  logic [15:0]   pic_height,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [W1P-1:0] mem_rd_data,
    output logic          init_o,
    output logic          new_pic_o,
    output logic [W1P*W_SIZE-1:0] pixel_o,
    output logic          pixel_o_en,
    input  logic          ready_for_next_col,
    output logic [15:0]   band_idx
);

    localparam int GUARD_W = (RDY_GUARD < 1) ? 1 : $clog2(RDY_GUARD + 1);
    localparam int GAP_W   = (BAND_GAP < 2) ? 1 : $clog2(BAND_GAP);

    scan_state_e       state_q;
    logic [15:0]       picW_q;
    logic [15:0]       picH_q;
    logic [15:0]       band_q;
    logic [15:0]       col_q;
    logic [AW-1:0]     bandBase_q;
    logic              pause_q;
    logic [GUARD_W-1:0] guard_q;
    logic [GAP_W-1:0]  gap_q;
    logic              go_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              init_q;
    logic              newPic_q;
    logic              pixelEn_q;
    col_t              pixel_q;

    logic              colValid;
    col_t              colData;
    logic              rdyOk;

    assign rdyOk = ready_for_next_col && (guard_q == '0);

    vj_col_gather #(
        .AW (AW)
    ) u_gather (
        .clk_i       (clk),
        .rst_i       (rstn),
        .go_i        (go_q),
        .col_base_i  (bandBase_q + AW'(col_q)),
        .stride_i    (AW'(picW_q)),
        .rd_data_i   (mem_rd_data),
        .rd_en_o     (mem_rd_en),
        .rd_addr_o   (mem_addr),
        .col_valid_o (colValid),
        .col_data_o  (colData)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= S_IDLE;
            picW_q     <= '0;
            picH_q     <= '0;
            band_q     <= '0;
            col_q      <= '0;
            bandBase_q <= '0;
            pause_q    <= 1'b0;
            guard_q    <= '0;
            gap_q      <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
            newPic_q   <= 1'b0;
            pixelEn_q  <= 1'b0;
            pixel_q    <= '0;
        end else begin
            init_q    <= 1'b0;
            newPic_q  <= 1'b0;
            pixelEn_q <= 1'b0;
            pixel_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            go_q      <= 1'b0;
            if (guard_q != '0) begin
                guard_q <= guard_q - GUARD_W'(1);
            end
            case (state_q)
                // done_q marks the done cycle, in which a new start must be ignored.
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start && !done_q) begin
                        picW_q <= pic_width;
                        picH_q <= pic_height;
                        busy_q <= 1'b1;
                        if (pic_width < 16'(W_SIZE) || pic_height < 16'(W_SIZE)) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            band_q     <= '0;
                            bandBase_q <= '0;
                            init_q     <= 1'b1;
                            newPic_q   <= 1'b1;
                            state_q    <= S_BAND_INIT;
                        end
                    end
                end
                S_BAND_INIT: begin
                    pause_q <= 1'b0;
                    state_q <= S_PAUSE;
                end
                S_PAUSE: begin
                    if (pause_q) begin
                        col_q   <= '0;
                        go_q    <= 1'b1;
                        state_q <= S_GATHER;
                    end else begin
                        pause_q <= 1'b1;
                    end
                end
                // col_valid still reflects the previous column during the go cycle.
                S_GATHER: begin
                    if (colValid && !go_q) begin
                        if (col_q < 16'(W_SIZE)) begin
                            pixel_q   <= colData;
                            pixelEn_q <= 1'b1;
                            guard_q   <= GUARD_W'(RDY_GUARD);
                            state_q   <= S_ISSUE;
                        end else begin
                            state_q <= S_WAIT_RDY;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (rdyOk) begin
                        pixel_q   <= colData;
                        pixelEn_q <= 1'b1;
                        guard_q   <= GUARD_W'(RDY_GUARD);
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (col_q == picW_q - 16'd1) begin
                        state_q <= S_END_WAIT;
                    end else begin
                        col_q   <= col_q + 16'd1;
                        go_q    <= 1'b1;
                        state_q <= S_GATHER;
                    end
                end
                S_END_WAIT: begin
                    if (rdyOk) begin
                        gap_q   <= GAP_W'(BAND_GAP - 1);
                        state_q <= S_GAP;
                    end
                end
                // busy_q stays high through the done cycle and drops in IDLE.
                S_GAP: begin
                    if (gap_q == '0) begin
                        if (band_q == picH_q - 16'(W_SIZE)) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            band_q     <= band_q + 16'd1;
                            bandBase_q <= bandBase_q + AW'(picW_q);
                            init_q     <= 1'b1;
                            state_q    <= S_BAND_INIT;
                        end
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign init_o     = init_q;
    assign new_pic_o  = newPic_q;
    assign pixel_o    = pixel_q;
    assign pixel_o_en = pixelEn_q;
    assign band_idx   = band_q;

endmodule

// File: tb/tb_vj_scan_ctrl.sv
// Directed self-checking bench for vj_scan_ctrl with a RAM[a]=a[7:0] frame store
// and a column model computed from band, column and frame width.
module tb_vj_scan_ctrl;

    localparam int W    = 24;
    localparam int PB   = 8;
    localparam int AW   = 20;

    logic              clk;
    logic              rstn;
    logic              start;
    logic [15:0]       pic_width;
    logic [15:0]       pic_height;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [PB-1:0]     memRdData;
    logic              init_o;
    logic              new_pic_o;
    logic [PB*W-1:0]   pixel_o;
    logic              pixel_o_en;
    logic              ready;
    logic [15:0]       band_idx;

    int checkCount = 0;
    int errorCount = 0;

    int scanId     = 0;
    int curWidth   = 24;
    bit holdReady  = 1'b0;

    int seenScan    = -1;
    int bandInScan  = 0;
    int colInBand   = 0;
    int initTotal   = 0;
    int issueCount  = 0;
    int doneCount   = 0;
    int errCount    = 0;
    int rdSeen      = 0;
    int cycleCnt    = 0;
    int lastIssue   = 0;
    bit prevEn      = 1'b0;

    vj_scan_ctrl #(
        .AW        (AW),
        .RDY_GUARD (2),
        .BAND_GAP  (16)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .start              (start),
        .pic_width          (pic_width),
        .pic_height         (pic_height),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .mem_rd_en          (mem_rd_en),
        .mem_addr           (mem_addr),
        .mem_rd_data        (memRdData),
        .init_o             (init_o),
        .new_pic_o          (new_pic_o),
        .pixel_o            (pixel_o),
        .pixel_o_en         (pixel_o_en),
        .ready_for_next_col (ready),
        .band_idx           (band_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame RAM: every byte holds the low 8 bits of its own address, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) memRdData <= mem_addr[7:0];
    end

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [255:0] expectedColumn(int w, int b, int j);
        logic [255:0] v;
        int a;
        v = '0;
        for (int p = 0; p < W; p++) begin
            a = b * w + j + p * w;
            v[PB*(W-p)-1 -: PB] = a[7:0];
        end
        return v;
    endfunction

    // Event monitor: samples on the falling edge and is the only driver of ready.
    initial begin
        ready = 1'b0;
        forever begin
            @(negedge clk);
            cycleCnt++;
            if (mem_rd_en) rdSeen++;
            if (done) doneCount++;
            if (err) errCount++;
            if (init_o) begin
                if (seenScan != scanId) begin
                    seenScan   = scanId;
                    bandInScan = 0;
                end else begin
                    bandInScan++;
                end
                checkOutput("newPic", new_pic_o, (bandInScan == 0));
                checkOutput("bandIdx", band_idx, bandInScan);
                initTotal++;
                colInBand = 0;
            end
            if (prevEn && !pixel_o_en) checkOutput("pixelClr", pixel_o, 0);
            if (pixel_o_en) begin
                checkOutput("colData", pixel_o, expectedColumn(curWidth, bandInScan, colInBand));
                if (holdReady && colInBand >= W)
                    checkOutput("issueSpacing", (cycleCnt - lastIssue) >= W + 1, 1);
                lastIssue = cycleCnt;
                colInBand++;
                issueCount++;
            end
            prevEn = pixel_o_en;
            ready  = holdReady || (colInBand >= W);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int w, input int h, input bit hold, input bit poke);
        int i0, iss0, d0, e0, bands;
        bit seen;
        bands = h - W + 1;
        scanId++;
        curWidth  = w;
        holdReady = hold;
        i0   = initTotal;
        iss0 = issueCount;
        d0   = doneCount;
        e0   = errCount;
        pic_width  = 16'(w);
        pic_height = 16'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (poke && c == 100) begin
                pic_width = 16'd20;
                start = 1'b1;
            end
            if (poke && c == 101) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        start = 1'b0;
        if (!seen) begin
            checkOutput("doneTimeout", 0, 1);
            return;
        end
        checkOutput("doneBusy", busy, 1);
        checkOutput("doneErr", err, 0);
        if (poke) begin
            pic_width  = 16'd24;
            pic_height = 16'd24;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        checkOutput("busyDoneAfter", {busy, done}, 0);
        repeat (30) tick();
        checkOutput("initCount", initTotal - i0, bands);
        checkOutput("issueCount", issueCount - iss0, bands * w);
        checkOutput("doneCount", doneCount - d0, 1);
        checkOutput("errCount", errCount - e0, 0);
    endtask

    initial begin
        int r0, d0, e0, i0;
        bit reached;
        rstn       = 1'b1;
        start      = 1'b0;
        pic_width  = '0;
        pic_height = '0;
        repeat (3) tick();
        checkOutput("rstFlags", {busy, done, err, mem_rd_en, init_o, new_pic_o, pixel_o_en}, 0);
        checkOutput("rstPixel", pixel_o, 0);
        checkOutput("rstAddrBand", {mem_addr, band_idx}, 0);
        rstn = 1'b0;
        repeat (2) tick();

        $display("[TB] single band 24x24, ready only at band end");
        applyStimulus(24, 24, 1'b0, 1'b0);

        $display("[TB] two bands 26x25 with start pokes while busy and in done cycle");
        applyStimulus(26, 25, 1'b0, 1'b1);

        $display("[TB] ready held high, width 30");
        applyStimulus(30, 24, 1'b1, 1'b0);
        holdReady = 1'b0;

        $display("[TB] config errors");
        r0 = rdSeen; d0 = doneCount; e0 = errCount; i0 = initTotal;
        pic_width = 16'd20; pic_height = 16'd48; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("errWidthPulse", {done, err, busy}, 3'b111);
        tick();
        checkOutput("errWidthAfter", {done, err, busy}, 0);
        pic_width = 16'd40; pic_height = 16'd23; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("errHeightPulse", {done, err}, 2'b11);
        repeat (10) tick();
        checkOutput("errNoReads", rdSeen - r0, 0);
        checkOutput("errNoInit", initTotal - i0, 0);
        checkOutput("errDoneCount", {doneCount - d0, errCount - e0}, {32'd2, 32'd2});

        $display("[TB] reset during gather of column 10");
        scanId++;
        curWidth = 24;
        d0 = doneCount;
        i0 = issueCount;
        pic_width = 16'd24; pic_height = 16'd24; start = 1'b1;
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (issueCount - i0 >= 10) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("reachCol10", reached, 1);
        repeat (5) tick();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        checkOutput("abortFlags", {busy, done, err, mem_rd_en, init_o, new_pic_o, pixel_o_en}, 0);
        checkOutput("abortPixel", pixel_o, 0);
        checkOutput("abortAddrBand", {mem_addr, band_idx}, 0);
        r0 = rdSeen;
        repeat (60) tick();
        checkOutput("abortNoDone", doneCount - d0, 0);
        checkOutput("abortNoReads", rdSeen - r0, 0);
        applyStimulus(24, 24, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vj_scan_ctrl.md
Name: vj_scan_ctrl

Overview:
- Frame scan sequencer in front of the vj cascade core.
- Reads a stored greyscale frame from a byte-wide, 1-cycle-latency frame RAM.
- Assembles W_SIZE-tall pixel columns and drives vj's init / pixel_i / pixel_i_en in row-band order, pacing columns on vj's ready_for_next_col.
- Replaces the behavioural bench driver so the vj pipeline can run stand-alone in hardware.

Parameters:
W_SIZE, 24, detection window height/width in pixels (column vector depth).
W1P, 8, bits per pixel.
AW, 20, frame RAM address width.
RDY_GUARD, 2, cycles after a column issue during which ready_for_next_col is ignored.
BAND_GAP, 16, idle cycles between the end of one band and the next init pulse.

Ports:
clk  in  1  system clock.
rstn  in  1  reset; synchronous, active-high (port keeps the codebase name; asserted = 1).
start  in  1  one-cycle pulse, begin a frame scan; ignored while busy.
pic_width  in  16  frame width in pixels, sampled on accepted start.
pic_height  in  16  frame height in pixels, sampled on accepted start.
busy  out  1  high from accepted start until the done cycle inclusive.
done  out  1  one-cycle pulse at end of frame, or on config error.
err  out  1  one-cycle pulse, coincident with done, when width or height < W_SIZE.
mem_rd_en  out  1  frame RAM read strobe.
mem_addr  out  AW  frame RAM byte address, row-major (row*pic_width + col).
mem_rd_data  in  W1P  RAM data, valid the cycle after mem_rd_en.
init_o  out  1  one-cycle band-start pulse to vj.init.
new_pic_o  out  1  coincident with init_o for band 0 only.
pixel_o  out  W1P*W_SIZE  column vector; window row p at bits [W1P*(W_SIZE-p)-1 -: W1P], row 0 at MSB.
pixel_o_en  out  1  one-cycle column valid.
ready_for_next_col  in  1  from vj; level, high when vj accepts another column.
band_idx  out  16  current band number (top row of band).

Behaviour:
- Reset: all outputs 0, state IDLE, column register cleared. Reset mid-scan aborts on the next edge with no done pulse; RAM reads in flight are discarded.
- Accepted start in IDLE: latch pic_width and pic_height.
  - If either < W_SIZE: done=err=1 for one cycle, back to IDLE; no RAM reads, no init.
- States:
  - IDLE -> BAND_INIT on accepted valid start.
  - BAND_INIT (1 cycle): init_o=1, new_pic_o=(band==0). Then 2 PAUSE cycles -> GATHER.
  - GATHER: W_SIZE consecutive reads for column j, addresses band_base+j + p*pic_width for p=0..W_SIZE-1. Row address is incremented by pic_width each cycle; no multiplier. Data captured into slot p one cycle after its read, so a column is complete W_SIZE+1 cycles after its first read.
  - ISSUE (1 cycle): pixel_o = assembled column, pixel_o_en=1. pixel_o returns to 0 the following cycle.
  - Prefill: columns j<W_SIZE are issued as soon as assembled, no ready check; then GATHER j+1.
  - Columns j>=W_SIZE: gather, then WAIT_RDY. Issue when ready_for_next_col=1, guard counter expired, and column assembled.
  - Guard: counter loaded with RDY_GUARD on every issue. ready_for_next_col is ignored while the counter is nonzero, which prevents a stale ready level from releasing two columns.
  - After column pic_width-1 is issued: END_WAIT (guard applies) until ready_for_next_col=1, then GAP for BAND_GAP cycles. Then band+1 -> BAND_INIT, with band_base += pic_width.
- Last band is pic_height-W_SIZE. After its GAP: done=1 and busy=1 for that cycle, then IDLE with busy=0.
- start arriving in the done cycle or while busy is ignored.
- ready_for_next_col is never required during prefill; asserting it then has no effect.
- Address arithmetic is AW-bit unsigned. pic_width*pic_height must fit in AW bits; out of range is not checked (caller's responsibility).
- band_idx updates on entry to BAND_INIT.

Decomposition:
- Shared package/global include holds: W_SIZE, W1P, the scan state enum, and the column-slot index/packing helper. This packing helper is the same one used by vj's column input.
- One natural sub-module: vj_col_gather. It owns the read-address walk, 1-cycle data capture and W_SIZE-slot shift/pack; interface is go/col_base/stride -> col_valid/col_data.
- The FSM, band/column counters and guard logic stay in vj_scan_ctrl.

Test Plan:
- RAM[a]=a[7:0]; width=24, height=24; ready tied 0 except at band end: 1 init (new_pic_o=1), 24 columns, no ready waits during prefill. Column 5 row p = (p*24+5)[7:0]. done once, err=0.
- width=26, height=25: 2 bands; new_pic_o only on band 0; each band gives 24 prefill columns + 2 ready-paced columns; band 1 column 0 row 0 = RAM[26]; band_idx 0 then 1.
- ready_for_next_col held 1 continuously, width=30: post-prefill issues spaced >= max(RDY_GUARD+1, W_SIZE+1) cycles; exactly 30 pixel_o_en per band.
- width=20, height=48 start: done=err=1 the following cycle, mem_rd_en never asserted, busy low afterwards.
- rstn=1 during GATHER of band 0 column 10: all outputs 0 next cycle, no done; a fresh start then completes normally.
- start pulsed while busy (and again in the done cycle): ignored; exactly one done per accepted start.
